// File: rtl/multiplier_pkg.sv
// Shared constants and reference helper for the pipelined multiplier.
// Optional overflow output is enabled with MULTIPLIER_OVERFLOW_EN.
package multiplier_pkg;

    localparam int MULT_MAX_STAGES = 8;

    typedef enum logic [1:0] {
        PP_LL,
        PP_LH,
        PP_HL,
        PP_HH
    } pp_sel_e;

    // Low len bits of a*b; intended for reference models, not for the datapath.
    function automatic logic [63:0] mult_lo(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          len
    );
        logic [127:0] p;
        logic [63:0]  mask;
        p    = {64'd0, a} * {64'd0, b};
        mask = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
        return p[63:0] & mask;
    endfunction

endpackage

// File: rtl/mult_pipe_reg.sv
// Fixed-depth delay line with synchronous active-high reset.
// Used for the trailing output ranks of the multiplier.
module mult_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/multiplier.sv
// Pipelined unsigned multiplier returning the low DATA_LEN bits of a*b.
// Define MULTIPLIER_OVERFLOW_EN to add the aligned overflow output.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
`ifdef MULTIPLIER_OVERFLOW_EN
    ,
    output logic                overflow
`endif
);

    localparam int W  = DATA_LEN;
    localparam int LO = W / 2;
    localparam int PS = (PIPELINE_STAGE > MULT_MAX_STAGES) ? MULT_MAX_STAGES :
                        (PIPELINE_STAGE < 1) ? 1 : PIPELINE_STAGE;
`ifdef MULTIPLIER_OVERFLOW_EN
    localparam int PW = 2 * W;
`else
    // Without overflow only the low half is ever observed, so carry no more.
    localparam int PW = W;
`endif

    logic [PW-1:0] a_lo;
    logic [PW-1:0] a_hi;
    logic [PW-1:0] b_lo;
    logic [PW-1:0] b_hi;
    logic [PW-1:0] pp_d [4];
    logic [PW-1:0] prod_w;

    function automatic logic [PW-1:0] pp_sum(
        input logic [PW-1:0] ll,
        input logic [PW-1:0] lh,
        input logic [PW-1:0] hl,
        input logic [PW-1:0] hh
    );
        return ll + ((lh + hl) << LO) + (hh << (2 * LO));
    endfunction

    assign a_lo = PW'(a[LO-1:0]);
    assign a_hi = PW'(a[W-1:LO]);
    assign b_lo = PW'(b[LO-1:0]);
    assign b_hi = PW'(b[W-1:LO]);

    always_comb begin
        pp_d[PP_LL] = a_lo * b_lo;
        pp_d[PP_LH] = a_lo * b_hi;
        pp_d[PP_HL] = a_hi * b_lo;
        pp_d[PP_HH] = a_hi * b_hi;
    end

    if (PS == 1) begin : g_comb
        assign prod_w = pp_sum(pp_d[PP_LL], pp_d[PP_LH],
                               pp_d[PP_HL], pp_d[PP_HH]);
    end else begin : g_pipe
        logic [PW-1:0] pp_q [4];
        logic [PW-1:0] acc_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    pp_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    pp_q[i] <= pp_d[i];
                end
            end
        end

        assign acc_d = pp_sum(pp_q[PP_LL], pp_q[PP_LH],
                              pp_q[PP_HL], pp_q[PP_HH]);

        if (PS == 2) begin : g_two
            assign prod_w = acc_d;
        end else begin : g_acc
            logic [PW-1:0] acc_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end

            if (PS == 3) begin : g_three
                assign prod_w = acc_q;
            end else begin : g_delay
                mult_pipe_reg #(
                    .WIDTH (PW),
                    .DEPTH (PS - 3)
                ) u_delay (
                    .clk    (clk),
                    .reset  (reset),
                    .data_i (acc_q),
                    .data_o (prod_w)
                );
            end
        end
    end

    assign result = prod_w[W-1:0];
`ifdef MULTIPLIER_OVERFLOW_EN
    assign overflow = |prod_w[PW-1:W];
`endif

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier at several depths and widths.
// Overflow is checked when MULTIPLIER_OVERFLOW_EN is defined.
module tb_multiplier;
    import multiplier_pkg::*;

    typedef struct {
        int          due;
        logic [63:0] lo;
        bit          ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [12:0] r3;
    logic [31:0] r5;
    logic        o1;
    logic        o2;
    logic        o3;
    logic        o5;

    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq [4][$];
    exp_t mon_e;

    always #5 clk = ~clk;

    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_ps2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r2)
`ifdef MULTIPLIER_OVERFLOW_EN
        , .overflow(o2)
`endif
    );
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) u_ps1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r1)
`ifdef MULTIPLIER_OVERFLOW_EN
        , .overflow(o1)
`endif
    );
    multiplier #(.DATA_LEN(13), .PIPELINE_STAGE(3)) u_ps3 (
        .clk(clk), .reset(reset), .a(a[12:0]), .b(b[12:0]), .result(r3)
`ifdef MULTIPLIER_OVERFLOW_EN
        , .overflow(o3)
`endif
    );
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(5)) u_ps5 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(r5)
`ifdef MULTIPLIER_OVERFLOW_EN
        , .overflow(o5)
`endif
    );

`ifndef MULTIPLIER_OVERFLOW_EN
    assign o1 = 1'b0;
    assign o2 = 1'b0;
    assign o3 = 1'b0;
    assign o5 = 1'b0;
`endif

    function automatic int ps_of(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int len_of(input int i);
        return (i == 2) ? 13 : 32;
    endfunction

    function automatic logic [63:0] res_of(input int i);
        case (i)
            0: return {32'd0, r2};
            1: return {32'd0, r1};
            2: return {51'd0, r3};
            default: return {32'd0, r5};
        endcase
    endfunction

    function automatic bit ovf_of(input int i);
        case (i)
            0: return o2;
            1: return o1;
            2: return o3;
            default: return o5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A reset edge wipes every operation not yet out of the pipeline.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (reset === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < sbq[i].size(); j++) begin
                    if (sbq[i][j].due >= cyc) begin
                        e = sbq[i][j];
                        e.lo = 64'd0;
                        e.ovf = 1'b0;
                        sbq[i][j] = e;
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic rst);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] full;
        step();
        #1;
        a = av;
        b = bv;
        reset = rst;
        for (int i = 0; i < 4; i++) begin
            mask = (64'd1 << len_of(i)) - 64'd1;
            am = {32'd0, av} & mask;
            bm = {32'd0, bv} & mask;
            full = am * bm;
            e.due = cyc + ps_of(i) - 1;
            e.lo = mult_lo(am, bm, len_of(i));
            e.ovf = (full >> len_of(i)) != 64'd0;
            sbq[i].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            while (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
                mon_e = sbq[i].pop_front();
                if (mon_e.due < cyc) begin
                    chk($sformatf("late ps%0d due%0d", ps_of(i), mon_e.due), 64'(cyc), 64'(mon_e.due));
                end else begin
                    chk($sformatf("result ps%0d cyc%0d", ps_of(i), cyc), res_of(i), mon_e.lo);
`ifdef MULTIPLIER_OVERFLOW_EN
                    chk($sformatf("overflow ps%0d cyc%0d", ps_of(i), cyc),
                        64'(ovf_of(i)), 64'(mon_e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a = 32'd0;
        b = 32'd0;
        repeat (3) step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_state ps%0d", ps_of(i)), res_of(i), 64'd0);
            chk($sformatf("reset_ovf ps%0d", ps_of(i)), 64'(ovf_of(i)), 64'd0);
        end

        issue(32'd3, 32'd5, 1'b0);
        issue(32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(32'h0001_0000, 32'h0001_0000, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            issue(32'(k), 32'(k), 1'b0);
        end

        issue(32'd7, 32'd9, 1'b0);
        issue(32'd7, 32'd9, 1'b1);
        issue(32'd0, 32'd0, 1'b0);
        issue(32'd0, 32'd0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] av;
            logic [31:0] bv;
            av = $urandom;
            bv = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                av = av & 32'h0000_FFFF;
                bv = bv & 32'h0000_FFFF;
            end
            issue(av, bv, ($urandom_range(0, 39) == 0));
        end

        issue(32'd0, 32'd0, 1'b0);
        repeat (8) step();
        #7;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain ps%0d", ps_of(i)), 64'(sbq[i].size()), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
